// File: rtl/sdhc_pkg.sv
// Shared types and CRC16-CCITT helper for the SD DAT-line DDR receiver.
package sdhc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        DATA,
        CRC,
        ENDBIT
    } sd_rx_state_e;

    localparam int unsigned CRC_W      = 16;
    localparam int unsigned DAT_LINES  = 4;
    localparam logic [15:0] CRC16_POLY = 16'h1021;

    // One serial step of x^16 + x^12 + x^5 + 1, MSB-first.
    function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/sd_crc16_ser.sv
// Bit-serial CRC16-CCITT accumulator with synchronous clear and shift enable.
module sd_crc16_ser
    import sdhc_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             bit_i,
    output logic [CRC_W-1:0] crc_o
);

    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = '0;
        end else if (en_i) begin
            crc_d = crc16_next(crc_q, bit_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sd_dat_ddr_rx.sv
// DDR50 4-bit SD data block receiver: start-bit hunt, byte assembly,
// per-line/per-edge CRC16 check, end-bit check and sticky status.
module sd_dat_ddr_rx
    import sdhc_pkg::*;
#(
    parameter int unsigned BLOCK_BYTES = 512,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] dat_q1_i,
    input  logic [3:0] dat_q2_i,
    input  logic       start_i,
    input  logic       abort_i,
    output logic       busy_o,
    output logic [7:0] data_o,
    output logic       data_valid_o,
    output logic       done_o,
    output logic       crc_err_o,
    output logic       end_err_o,
    output logic       timeout_o
);

    localparam int unsigned CNT_W  = $clog2(BLOCK_BYTES + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned CCNT_W = 4;

    sd_rx_state_e      state_q, state_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [CCNT_W-1:0] crc_cnt_q, crc_cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              crc_err_q, crc_err_d;
    logic              end_err_q, end_err_d;
    logic              timeout_q, timeout_d;

    logic              crc_clr_c;
    logic              crc_en_c;
    logic              crc_mismatch_c;
    logic [CCNT_W-1:0] crc_idx_c;
    logic [CRC_W-1:0]  crc_rise [DAT_LINES];
    logic [CRC_W-1:0]  crc_fall [DAT_LINES];

    // Eight independent accumulators: one per DAT line per clock edge.
    for (genvar n = 0; n < DAT_LINES; n++) begin : g_crc
        sd_crc16_ser u_crc_rise (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (crc_clr_c),
            .en_i   (crc_en_c),
            .bit_i  (dat_q1_i[n]),
            .crc_o  (crc_rise[n])
        );
        sd_crc16_ser u_crc_fall (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (crc_clr_c),
            .en_i   (crc_en_c),
            .bit_i  (dat_q2_i[n]),
            .crc_o  (crc_fall[n])
        );
    end

    // CRC registers are frozen during the CRC phase, so walk them MSB-first by index.
    always_comb begin
        crc_idx_c      = CCNT_W'(4'd15 - crc_cnt_q);
        crc_mismatch_c = 1'b0;
        for (int n = 0; n < DAT_LINES; n++) begin
            if ((dat_q1_i[n] != crc_rise[n][crc_idx_c]) ||
                (dat_q2_i[n] != crc_fall[n][crc_idx_c])) begin
                crc_mismatch_c = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        crc_cnt_d  = crc_cnt_q;
        tmo_d      = tmo_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        done_d     = 1'b0;
        crc_err_d  = crc_err_q;
        end_err_d  = end_err_q;
        timeout_d  = timeout_q;
        crc_clr_c  = 1'b0;
        crc_en_c   = 1'b0;

        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d   = WAIT_START;
                        crc_err_d = 1'b0;
                        end_err_d = 1'b0;
                        timeout_d = 1'b0;
                        crc_clr_c = 1'b1;
                        tmo_d     = TMO_W'(TIMEOUT_CYC);
                    end
                end
                WAIT_START: begin
                    if ((dat_q1_i == 4'h0) && (dat_q2_i == 4'h0)) begin
                        state_d    = DATA;
                        byte_cnt_d = '0;
                    end else if (tmo_q <= TMO_W'(1)) begin
                        tmo_d     = '0;
                        timeout_d = 1'b1;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        tmo_d = tmo_q - TMO_W'(1);
                    end
                end
                DATA: begin
                    valid_d    = 1'b1;
                    data_d     = {dat_q1_i, dat_q2_i};
                    crc_en_c   = 1'b1;
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    if (byte_cnt_q == CNT_W'(BLOCK_BYTES - 1)) begin
                        state_d   = CRC;
                        crc_cnt_d = '0;
                    end
                end
                CRC: begin
                    if (crc_mismatch_c) begin
                        crc_err_d = 1'b1;
                    end
                    crc_cnt_d = crc_cnt_q + CCNT_W'(1);
                    if (crc_cnt_q == CCNT_W'(15)) begin
                        state_d = ENDBIT;
                    end
                end
                ENDBIT: begin
                    if ({dat_q1_i, dat_q2_i} != 8'hFF) begin
                        end_err_d = 1'b1;
                    end
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            crc_cnt_q  <= '0;
            tmo_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            crc_err_q  <= 1'b0;
            end_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            crc_cnt_q  <= crc_cnt_d;
            tmo_q      <= tmo_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            crc_err_q  <= crc_err_d;
            end_err_q  <= end_err_d;
            timeout_q  <= timeout_d;
        end
    end

    assign busy_o       = busy_q;
    assign data_o       = data_q;
    assign data_valid_o = valid_q;
    assign done_o       = done_q;
    assign crc_err_o    = crc_err_q;
    assign end_err_o    = end_err_q;
    assign timeout_o    = timeout_q;

endmodule
